// File: rtl/holes_filler_ctrl_if.sv
// holes_filler_ctrl_if: pixel, line-buffer, filler and output signals of the
// hole-filling frame sequencer. master = sequencer side, slave = surroundings.
interface holes_filler_ctrl_if #(
  parameter int CW = 10
);
  // upstream raster stream
  logic          in_valid;
  logic          in_pix;
  logic          in_ready;
  // external 1-bit line buffer (1-cycle read latency)
  logic [CW-1:0] lb_rd_addr;
  logic          lb_rd_data;
  logic          lb_wr_en;
  logic [CW-1:0] lb_wr_addr;
  logic          lb_wr_data;
  // holes filler window
  logic          hf_clr;
  logic          hf_datavalid;
  logic          hf_pix_cur;
  logic          hf_pix_prev;
  logic          hf_pix_out;
  // downstream filled stream
  logic          out_valid;
  logic          out_pix;
  logic          out_ready;

  modport master (
    input  in_valid, in_pix, lb_rd_data, hf_pix_out, out_ready,
    output in_ready, lb_rd_addr, lb_wr_en, lb_wr_addr, lb_wr_data,
           hf_clr, hf_datavalid, hf_pix_cur, hf_pix_prev, out_valid, out_pix
  );

  modport slave (
    output in_valid, in_pix, lb_rd_data, hf_pix_out, out_ready,
    input  in_ready, lb_rd_addr, lb_wr_en, lb_wr_addr, lb_wr_data,
           hf_clr, hf_datavalid, hf_pix_cur, hf_pix_prev, out_valid, out_pix
  );
endinterface

// File: rtl/holes_filler_ctrl.sv
// holes_filler_ctrl: frame sequencer for the RLECCA hole-filling stage.
// Streams a binary raster through a one-row line buffer into the holes filler
// as (current, previous-row) pixel pairs, appends a zero flush column per row,
// clears the filler window between rows and returns the filled stream under
// valid/ready backpressure.
// Optional feature: define HFC_FILL_CNT_EN to build the 0->1 fill counter;
// otherwise fill_cnt is tied to zero.
module holes_filler_ctrl #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int CW    = 10,
  parameter int RW    = 9
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [19:0] fill_cnt,
  holes_filler_ctrl_if.master bus
);

  localparam logic [CW-1:0] LAST_COL = CW'(IMG_W - 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(IMG_H - 1);

  typedef enum logic [2:0] {S_IDLE, S_CLR, S_RUN, S_PAD, S_ROWEND, S_DONE} state_t;

  state_t        state;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          hf_clr_q;
  // S1: pixel accepted last cycle, waiting for its line-buffer read data
  logic          s1_vld;
  logic          s1_pix;
  logic [CW-1:0] s1_col;
  // first filler push of a row produces no output (window not yet centred)
  logic          first_dv;
  // filler output for the previous column is ready to be captured
  logic          cap_pend;
  logic          out_valid_q;
  logic          out_pix_q;

  logic stall, accept, s1_dv, pad_dv, dv, capture;

  // handshake and issue decisions for this cycle
  always_comb begin
    stall   = out_valid_q & ~bus.out_ready;
    accept  = (state == S_RUN) & ~stall & bus.in_valid;
    s1_dv   = s1_vld & ~stall;
    pad_dv  = (state == S_PAD) & ~s1_vld & ~stall;
    dv      = s1_dv | pad_dv;
    capture = cap_pend & ~stall;
  end

  assign bus.in_ready     = (state == S_RUN) & ~stall;
  // while S1 is held the same column is re-read so the data lines up on release
  assign bus.lb_rd_addr   = accept ? col : s1_col;
  assign bus.lb_wr_en     = s1_dv;
  assign bus.lb_wr_addr   = s1_col;
  assign bus.lb_wr_data   = s1_dv & s1_pix;
  assign bus.hf_clr       = hf_clr_q;
  assign bus.hf_datavalid = dv;
  assign bus.hf_pix_cur   = s1_dv & s1_pix;
  // row 0 has no previous row; line-buffer contents are stale there
  assign bus.hf_pix_prev  = s1_dv & (row != '0) & bus.lb_rd_data;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_pix      = out_pix_q;

  // frame/row sequencing with registered busy/done/hf_clr
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      col      <= '0;
      row      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      hf_clr_q <= 1'b0;
    end else begin
      hf_clr_q <= 1'b0;
      done     <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          state    <= S_CLR;
          row      <= '0;
          busy     <= 1'b1;
          hf_clr_q <= 1'b1;
        end
        S_CLR: begin
          col   <= '0;
          state <= S_RUN;
        end
        S_RUN: if (accept) begin
          if (col == LAST_COL) state <= S_PAD;
          else                 col   <= col + 1'b1;
        end
        S_PAD: if (pad_dv) state <= S_ROWEND;
        // the flush column's output must leave the window before it is cleared
        S_ROWEND: if (!cap_pend || !stall) begin
          if (row == LAST_ROW) state <= S_DONE;
          else begin
            row      <= row + 1'b1;
            state    <= S_CLR;
            hf_clr_q <= 1'b1;
          end
        end
        S_DONE: if (!out_valid_q) begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // S1 stage, capture tracking and output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld      <= 1'b0;
      s1_pix      <= 1'b0;
      s1_col      <= '0;
      first_dv    <= 1'b1;
      cap_pend    <= 1'b0;
      out_valid_q <= 1'b0;
      out_pix_q   <= 1'b0;
    end else begin
      if (accept) begin
        s1_vld <= 1'b1;
        s1_pix <= bus.in_pix;
        s1_col <= col;
      end else if (s1_dv) begin
        s1_vld <= 1'b0;
      end

      if (state == S_CLR) first_dv <= 1'b1;
      else if (dv)        first_dv <= 1'b0;

      if (dv && !first_dv) cap_pend <= 1'b1;
      else if (capture)    cap_pend <= 1'b0;

      if (capture) begin
        out_valid_q <= 1'b1;
        out_pix_q   <= bus.hf_pix_out;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

`ifdef HFC_FILL_CNT_EN
  // original pixel follows the filler window: orig2 is the column being emitted
  logic orig1, orig2, out_orig;

  // count accepted outputs turned from 0 to 1, saturating, cleared on start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      orig1    <= 1'b0;
      orig2    <= 1'b0;
      out_orig <= 1'b0;
      fill_cnt <= '0;
    end else begin
      if (dv) begin
        orig1 <= s1_dv & s1_pix;
        orig2 <= orig1;
      end
      if (capture) out_orig <= orig2;
      if (state == S_IDLE && start)
        fill_cnt <= '0;
      else if (out_valid_q && bus.out_ready && out_pix_q && !out_orig && fill_cnt != '1)
        fill_cnt <= fill_cnt + 1'b1;
    end
  end
`else
  assign fill_cnt = '0;
`endif

endmodule

// File: tb/tb_holes_filler_ctrl.sv
// tb_holes_filler_ctrl: drives frames through holes_filler_ctrl with a
// behavioural line buffer and a three-column holes filler stub, and compares
// the stream against an image-level fill rule: a 0 pixel becomes 1 when the
// pixel above is 1 and a horizontal neighbour in its own row is 1.
module tb_holes_filler_ctrl;
  localparam int W  = 4;
  localparam int H  = 3;
  localparam int CW = 2;
  localparam int RW = 2;
  localparam int N  = W * H;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        busy, done;
  logic [19:0] fill_cnt;

  int n_chk = 0, n_pass = 0, n_fail = 0;

  holes_filler_ctrl_if #(.CW(CW)) bus();

  holes_filler_ctrl #(.IMG_W(W), .IMG_H(H), .CW(CW), .RW(RW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .fill_cnt(fill_cnt), .bus(bus.master)
  );

  always #5 clk = ~clk;

  // line buffer: registered read, write port, optional preset to all ones
  logic lb_mem [W];
  logic lb_q = 1'b0;
  logic lb_preset = 1'b0;
  always @(posedge clk) begin
    lb_q <= lb_mem[bus.lb_rd_addr];
    if (lb_preset) for (int i = 0; i < W; i++) lb_mem[i] <= 1'b1;
    else if (bus.lb_wr_en) lb_mem[bus.lb_wr_addr] <= bus.lb_wr_data;
  end
  assign bus.lb_rd_data = lb_q;

  // filler stub: newest push in w_cur[0], emitted column is the middle one
  logic [2:0] w_cur = '0;
  logic [1:0] w_prv = '0;
  always @(posedge clk) begin
    if (bus.hf_clr) begin
      w_cur <= '0;
      w_prv <= '0;
    end else if (bus.hf_datavalid) begin
      w_cur <= {w_cur[1:0], bus.hf_pix_cur};
      w_prv <= {w_prv[0], bus.hf_pix_prev};
    end
  end
  assign bus.hf_pix_out = w_cur[1] | (w_prv[1] & (w_cur[2] | w_cur[0]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic exp_pix(input logic [N-1:0] im, input int r, input int c);
    logic up, lf, rt;
    if (im[r*W+c]) return 1'b1;
    if (r == 0) return 1'b0;
    up = im[(r-1)*W+c];
    lf = (c > 0)     ? im[r*W+c-1] : 1'b0;
    rt = (c < W - 1) ? im[r*W+c+1] : 1'b0;
    return up & (lf | rt);
  endfunction

  // vmode: 0 always valid, 1 every other cycle, 2 random
  // rmode: 0 always ready, 1 random, 2 five-cycle stall window
  task automatic run_frame(input logic [N-1:0] img, input int vmode, input int rmode,
                           input int abort_cyc, input bit mid_start, input string nm);
    logic got [N];
    int ip = 0, op = 0, ndone = 0, ndv = 0, nclr = 0, cyc = 0, post = 0, efill = 0;
    int rr, kk;
    logic v, rd, ecur, eprv;
    @(negedge clk);
    start = 1'b1;
    while (cyc < 400 && post < 3) begin
      @(negedge clk);
      start = mid_start && (cyc == 10);
      if (abort_cyc > 0 && cyc == abort_cyc) begin
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        #1;
        chk($sformatf("%s/abort_busy", nm), busy, 0);
        chk($sformatf("%s/abort_out_valid", nm), bus.out_valid, 0);
        chk($sformatf("%s/abort_in_ready", nm), bus.in_ready, 0);
        chk($sformatf("%s/abort_dv", nm), bus.hf_datavalid, 0);
        rst_n = 1'b1;
        start = 1'b0;
        return;
      end
      case (vmode)
        0:       v = (ip < N);
        1:       v = (ip < N) && (cyc % 2 == 0);
        default: v = (ip < N) && ($urandom_range(0, 1) == 1);
      endcase
      case (rmode)
        0:       rd = 1'b1;
        1:       rd = ($urandom_range(0, 3) != 0);
        default: rd = !(cyc >= 8 && cyc < 13);
      endcase
      bus.in_valid  = v;
      bus.in_pix    = v ? img[ip] : 1'b0;
      bus.out_ready = rd;
      #1;
      if (bus.out_valid && !bus.out_ready)
        chk($sformatf("%s/stall_quiet", nm),
            {29'd0, bus.in_ready, bus.lb_wr_en, bus.hf_datavalid}, 0);
      if (bus.hf_clr) begin
        nclr++;
        chk($sformatf("%s/clr_dv_excl", nm), bus.hf_datavalid, 0);
      end
      if (bus.hf_datavalid) begin
        rr = ndv / (W + 1);
        kk = ndv % (W + 1);
        ecur = 1'b0;
        eprv = 1'b0;
        if (rr < H && kk < W) begin
          ecur = img[rr*W+kk];
          if (rr > 0) eprv = img[(rr-1)*W+kk];
        end
        chk($sformatf("%s/dv%0d_cur", nm, ndv), bus.hf_pix_cur, ecur);
        chk($sformatf("%s/dv%0d_prev", nm, ndv), bus.hf_pix_prev, eprv);
        ndv++;
      end
      if (bus.in_valid && bus.in_ready) ip++;
      if (bus.out_valid && bus.out_ready) begin
        if (op < N) got[op] = bus.out_pix;
        op++;
      end
      if (done) ndone++;
      if (ndone > 0) post++;
      cyc++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    chk($sformatf("%s/done_once", nm), ndone, 1);
    chk($sformatf("%s/in_count", nm), ip, N);
    chk($sformatf("%s/out_count", nm), op, N);
    chk($sformatf("%s/dv_count", nm), ndv, H * (W + 1));
    chk($sformatf("%s/clr_count", nm), nclr, H);
    for (int i = 0; i < N; i++) begin
      if (exp_pix(img, i / W, i % W) && !img[i]) efill++;
      if (i < op) chk($sformatf("%s/pix%0d", nm, i), got[i], exp_pix(img, i / W, i % W));
    end
    chk($sformatf("%s/busy_after", nm), busy, 0);
`ifdef HFC_FILL_CNT_EN
    chk($sformatf("%s/fill_cnt", nm), fill_cnt, efill);
`else
    chk($sformatf("%s/fill_cnt", nm), fill_cnt, 0);
`endif
  endtask

  initial begin
    logic [N-1:0] img_a;
    logic [W-1:0] rows [H];
    bus.in_valid  = 1'b0;
    bus.in_pix    = 1'b0;
    bus.out_ready = 1'b1;
    rows[0] = 4'b0110;
    rows[1] = 4'b1001;
    rows[2] = 4'b1111;
    img_a = '0;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        img_a[r*W+c] = rows[r][W-1-c];

    // reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst/busy", busy, 0);
    chk("rst/done", done, 0);
    chk("rst/in_ready", bus.in_ready, 0);
    chk("rst/hf_clr", bus.hf_clr, 0);
    chk("rst/hf_dv", bus.hf_datavalid, 0);
    chk("rst/hf_cur", bus.hf_pix_cur, 0);
    chk("rst/hf_prev", bus.hf_pix_prev, 0);
    chk("rst/lb_wr_en", bus.lb_wr_en, 0);
    chk("rst/lb_rd_addr", bus.lb_rd_addr, 0);
    chk("rst/lb_wr_addr", bus.lb_wr_addr, 0);
    chk("rst/out_valid", bus.out_valid, 0);
    chk("rst/out_pix", bus.out_pix, 0);
    chk("rst/fill_cnt", fill_cnt, 0);
    rst_n = 1'b1;

    // stale all-ones line buffer: row 0 must still see prev = 0
    @(negedge clk);
    lb_preset = 1'b1;
    @(negedge clk);
    lb_preset = 1'b0;

    run_frame(img_a, 0, 0, 0, 1'b0, "directed");
    run_frame(img_a, 1, 2, 0, 1'b1, "stall_toggle");
    run_frame(N'($urandom), 0, 0, 6, 1'b0, "abort");
    run_frame(img_a, 0, 1, 0, 1'b0, "after_abort");
    for (int f = 0; f < 6; f++)
      run_frame(N'($urandom), 2, 1, 0, 1'b0, $sformatf("rand%0d", f));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/holes_filler_ctrl.md
# holes_filler_ctrl

Frame sequencer for the RLECCA hole-filling stage. It accepts a binary raster stream, keeps the previous row in an external 1-bit line buffer, and feeds the holes filler current/previous pixel pairs with correct `datavalid` gating. It also inserts the row-end flush column, clears the filler window between rows and returns the filled stream under valid/ready backpressure. It sits between the binarisation front end and the run-length encoder.

## Interface
- `IMG_W`, 640, pixels per row (≥2)
- `IMG_H`, 480, rows per frame (≥1)
- `CW`, 10, column counter/address width (2^CW ≥ IMG_W)
- `RW`, 9, row counter width (2^RW ≥ IMG_H)

- `clk` in 1 — single clock, all logic rising-edge
- `rst_n` in 1 — asynchronous, active-low reset
- `start` in 1 — frame start request, sampled in IDLE
- `busy` out 1 — high from leaving IDLE until DONE exits
- `done` out 1 — one-cycle pulse after the last output pixel is accepted
- `in_valid` / `in_pix` / `in_ready` — upstream pixel handshake (1/1/1)
- `lb_rd_addr` out CW, `lb_rd_data` in 1 — line buffer read, 1-cycle latency
- `lb_wr_en` out 1, `lb_wr_addr` out CW, `lb_wr_data` out 1 — line buffer write
- `hf_clr` out 1 — registered clear pulse to the filler window
- `hf_datavalid`, `hf_pix_cur`, `hf_pix_prev` out 1 — filler inputs
- `hf_pix_out` in 1 — filler output (combinational from its window)
- `out_valid` / `out_pix` / `out_ready` — downstream handshake (1/1/1)
- `fill_cnt` out 20 — number of output pixels changed 0→1 in the last frame

## Operation
- FSM states: IDLE, CLR, RUN, PAD, ROWEND, DONE.
- IDLE → CLR on `start`.
- CLR: `hf_clr`=1 for one cycle. Clears col=0. Goes to RUN.
- RUN: `in_ready`=1 when the S1 stage is free, or drains this cycle, and no stall.
  - On accept: `lb_rd_addr`=col; register `in_pix` into S1; col++.
  - After col reaches IMG_W−1 accepted → PAD.
- S1 (cycle after accept): `hf_datavalid`=1, `hf_pix_cur`=S1 pixel, `hf_pix_prev`=`lb_rd_data` (forced 0 on row 0).
  - Same cycle: `lb_wr_en`=1, `lb_wr_addr`=S1 column, `lb_wr_data`=S1 pixel. Read precedes write by one cycle, so there is no hazard.
- PAD: one `hf_datavalid` with cur=prev=0, issued once S1 has drained. Goes to ROWEND.
- ROWEND: row++.
  - Row == IMG_H → DONE.
  - Otherwise → CLR, which re-clears the window and sets col=0.
- Output capture: in the cycle after each `hf_datavalid`, except the first of a row, `hf_pix_out` is loaded into the `out_pix` register with `out_valid`=1. This yields exactly IMG_W outputs per row, and the last one is produced by PAD.
- Stall: while `out_valid` && !`out_ready`:
  - no new `hf_datavalid`, no `in_ready`, no line-buffer write;
  - S1 holds its contents.
- DONE: waits until `out_valid`=0, pulses `done`, then → IDLE.
- `start` outside IDLE is ignored.
- `rst_n` low mid-frame:
  - immediate abort to IDLE, all outputs to reset values;
  - the line-buffer contents are don't-care, since row 0 forces prev=0.

## Timing
- Reset values: `busy`, `done`, `in_ready`, `hf_*`, `lb_wr_en`, `out_valid`, `out_pix` = 0; `lb_*_addr` = 0; `fill_cnt` = 0.
- Latency: pixel accepted at cycle t → `hf_datavalid` at t+1 → output for that column registered at t+3 (column c is emitted after column c+1 or PAD is pushed).
- Row overhead: 3 cycles (PAD, ROWEND, CLR).
- `hf_clr` and `hf_datavalid` are never high in the same cycle.
- Sustained throughput with `out_ready`=1 and `in_valid`=1: 1 pixel/cycle within a row.

## Configuration
- `HFC_FILL_CNT_EN` defined:
  - `fill_cnt` increments for each accepted output where `out_pix`=1 and the original S1-column pixel was 0;
  - it saturates at 2^20−1, clears on `start`, and holds its value after `done`.
- Undefined: `fill_cnt` is tied to 0 and no counter logic is built.

## Test plan
- Reset: `rst_n`=0 mid-row → next cycle `busy`=0, `out_valid`=0, state IDLE; a later `start` runs the full frame correctly.
- 4×3 frame (rows 0110, 1001, 1111), always ready → 12 outputs.
  - Row 1 col 1 and col 2 become 1; all other pixels pass through unchanged.
  - `done` pulses once after the 12th accept; `fill_cnt`=2 with the macro defined.
- Row 0 with `lb_rd_data` forced to 1 → `hf_pix_prev`=0 throughout row 0; output equals input.
- `out_ready` low for 5 cycles mid-row → `out_pix` held stable, `in_ready`=0, `lb_wr_en`=0; no pixel is lost or duplicated.
- `in_valid` toggled every other cycle → `hf_datavalid` tracks accepts only; one PAD and one `hf_clr` per row; IMG_W outputs per row.
- Compile without `HFC_FILL_CNT_EN` → `fill_cnt`=0 after a frame containing fills.
